// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding, the halt word, and the stream byte width.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [31:0] HALT_WORD = 32'h0000007F;
   localparam int          BYTE_W    = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
// The slave modport is the loader; the master modport is the host/memory side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 6
);
   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_wren;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_addr, mem_wdata, mem_wren
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_addr, mem_wdata, mem_wren
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid is combinational
// on the 4th byte so the next word's first byte is taken without a stall.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [BYTE_W-1:0] byte_dat,
   output logic              word_valid,
   output logic [31:0]       word
);
   logic [1:0]  lane;
   // Only the three earlier bytes need storage; the 4th arrives on byte_dat.
   logic [23:0] sh;

   assign word_valid = byte_vld && (lane == 2'd3);
   assign word       = {byte_dat, sh};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane <= 2'd0;
         sh   <= 24'd0;
      end else if (clr) begin
         lane <= 2'd0;
         sh   <= 24'd0;
      end else if (byte_vld) begin
         lane <= lane + 2'd1;
         sh   <= {byte_dat, sh[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> sequential 32-bit imem writes, one cycle after each 4th byte.
// in_ready high in COUNT/DATA/CHECK only; sustains one byte per cycle, bubbles allowed.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         core_run,
   output logic         load_done,
   output logic         load_err
);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_t            state, state_nxt;
   logic              go, take, pk_vld, word_vld, cnt_bad, ck_ok;
   logic [31:0]       word;
   logic [7:0]        word_idx, count, acc;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [31:0]       mem_wdata_r;
   logic              mem_wren_r;

   assign bus.in_ready  = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);
   assign take          = bus.in_valid && bus.in_ready;
   assign pk_vld        = take && (state == ST_DATA);
   assign cnt_bad       = (bus.in_data == 8'd0) || (bus.in_data > DEPTH_B);
   assign ck_ok         = (bus.in_data == acc);
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_wren  = mem_wren_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               go        = 1'b1;
               state_nxt = ST_COUNT;
            end
         end
         ST_COUNT: if (take) state_nxt = cnt_bad ? ST_ERR : ST_DATA;
         ST_DATA:  if (word_vld && (word_idx + 8'd1 == count)) state_nxt = ST_CHECK;
         ST_CHECK: if (take) state_nxt = ck_ok ? ST_DONE : ST_ERR;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   imem_loader_byte_packer u_byte_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (go),
      .byte_vld   (pk_vld),
      .byte_dat   (bus.in_data),
      .word_valid (word_vld),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_idx    <= 8'd0;
         count       <= 8'd0;
         acc         <= 8'd0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'd0;
         mem_wren_r  <= 1'b0;
         core_run    <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         mem_wren_r <= 1'b0;
         if (go) begin
            word_idx  <= 8'd0;
            acc       <= 8'd0;
            core_run  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
         end
         if (take && (state == ST_COUNT)) begin
            count    <= bus.in_data;
            load_err <= cnt_bad;
         end
         if (pk_vld) acc <= acc ^ bus.in_data;
         if (word_vld) begin
            mem_addr_r  <= word_idx[ADDR_W-1:0];
            mem_wdata_r <= word;
            mem_wren_r  <= 1'b1;
            word_idx    <= word_idx + 8'd1;
         end
         if (take && (state == ST_CHECK)) begin
            load_done <= ck_ok;
            core_run  <= ck_ok;
            load_err  <= !ck_ok;
         end
      end
   end

endmodule
